// File: rtl/riscmc_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes, datapath mux selects.
// The controller output bundle is a packed struct so it can be zeroed as one value under reset.
package riscmc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_BRANCH = 4'd5,
    S_MULTI  = 4'd6
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LHI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_LM   = 4'b0110;
  localparam logic [3:0] OP_SM   = 4'b0111;
  localparam logic [3:0] OP_JAL  = 4'b1000;
  localparam logic [3:0] OP_JLR  = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1100;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_IMM    = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_NAND  = 2'b01;
  localparam logic [1:0] ALU_PASSB = 2'b10;

  localparam logic [1:0] A_REG     = 2'b00;

  localparam logic [1:0] B_REG     = 2'b00;
  localparam logic [1:0] B_IMM6    = 2'b01;
  localparam logic [1:0] B_IMM9    = 2'b10;

  localparam logic [1:0] WA_RC     = 2'b00;
  localparam logic [1:0] WA_RB     = 2'b01;
  localparam logic [1:0] WA_RA     = 2'b10;
  localparam logic [1:0] WA_IDX    = 2'b11;

  localparam logic [1:0] DIN_ALU   = 2'b00;
  localparam logic [1:0] DIN_MEM   = 2'b01;
  localparam logic [1:0] DIN_PC    = 2'b10;

  typedef struct packed {
    logic       ir_wen;
    logic       pc_wen;
    logic       mem_rd;
    logic       mem_wr;
    logic       rf_wen;
    logic       cz_en;
    logic       illegal;
    logic [1:0] pc_sel;
    logic [1:0] alu_a_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] alu_op;
    logic [1:0] rf_wadd_sel;
    logic [1:0] rf_din_sel;
  } ctrl_out_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic [1:0] alu_b_sel;
    logic [1:0] rf_wadd_sel;
  } exec_sel_t;

  // ALU selects stay valid from EXEC through MEM/WB so a combinational ALU result is stable.
  function automatic exec_sel_t exec_decode(input logic [3:0] op);
    exec_sel_t s;
    s = '{alu_op: ALU_ADD, alu_b_sel: B_REG, rf_wadd_sel: WA_RC};
    case (op)
      OP_NAND: s.alu_op = ALU_NAND;
      OP_ADI:  begin s.alu_b_sel = B_IMM6; s.rf_wadd_sel = WA_RB; end
      OP_LHI:  begin s.alu_op = ALU_PASSB; s.alu_b_sel = B_IMM9; s.rf_wadd_sel = WA_RA; end
      OP_LW:   begin s.alu_b_sel = B_IMM6; s.rf_wadd_sel = WA_RA; end
      OP_SW:   s.alu_b_sel = B_IMM6;
      default: s = s;
    endcase
    return s;
  endfunction

  // ir[1:0]: 10 = execute only if carry set, 01 = only if zero set, otherwise unconditional.
  function automatic logic cond_ok(input logic [1:0] cz, input logic carry, input logic zero);
    logic ok;
    ok = 1'b1;
    if (cz == 2'b10) ok = carry;
    if (cz == 2'b01) ok = zero;
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flags/handshake in, strobes and mux selects out.
// master is the controller side, slave is the datapath/memory side.
interface multicycle_ctrl_if #(
  parameter int IDX_W = 3
);
  logic [15:0]      ir;
  logic             carry_flag;
  logic             zero_flag;
  logic             eq;
  logic             mem_ready;

  logic             ir_wen;
  logic             pc_wen;
  logic             mem_rd;
  logic             mem_wr;
  logic             rf_wen;
  logic             cz_en;
  logic             illegal;
  logic [1:0]       pc_sel;
  logic [1:0]       alu_a_sel;
  logic [1:0]       alu_b_sel;
  logic [1:0]       alu_op;
  logic [1:0]       rf_wadd_sel;
  logic [1:0]       rf_din_sel;
  logic [IDX_W-1:0] reg_idx;
  logic [3:0]       state_id;

  modport master (
    input  ir, carry_flag, zero_flag, eq, mem_ready,
    output ir_wen, pc_wen, mem_rd, mem_wr, rf_wen, cz_en, illegal,
           pc_sel, alu_a_sel, alu_b_sel, alu_op, rf_wadd_sel, rf_din_sel,
           reg_idx, state_id
  );

  modport slave (
    output ir, carry_flag, zero_flag, eq, mem_ready,
    input  ir_wen, pc_wen, mem_rd, mem_wr, rf_wen, cz_en, illegal,
           pc_sel, alu_a_sel, alu_b_sel, alu_op, rf_wadd_sel, rf_din_sel,
           reg_idx, state_id
  );
endinterface

// File: rtl/multi_reg_seq.sv
// LM/SM mask scanner: a clear mask bit retires in one cycle, a set bit holds until mem_ready.
// last_o marks the retiring final slot; the pointer returns to 0 whenever the scan is idle.
module multi_reg_seq #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                active_i,
  input  logic [NUM_REGS-1:0] mask_i,
  input  logic                mem_ready_i,
  output logic [IDX_W-1:0]    reg_idx_o,
  output logic                bit_set_o,
  output logic                last_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_done;

  assign bit_set_o = mask_i[idx_q];
  assign slot_done = active_i & (~bit_set_o | mem_ready_i);
  assign last_o    = slot_done & (idx_q == IDX_W'(NUM_REGS - 1));
  assign reg_idx_o = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (!active_i || last_o) begin
      idx_d = '0;
    end else if (slot_done) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb plus branch and LM/SM sequencing.
// Memory accesses hold their strobe until mem_ready; all outputs are forced low while rst_n is low.
module multicycle_ctrl
  import riscmc_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  state_t           state_q, state_d;
  ctrl_out_t        raw;
  ctrl_out_t        gated;
  exec_sel_t        xs;
  logic [3:0]       opcode;
  logic             is_lm;
  logic             multi_active;
  logic             bit_set;
  logic             multi_last;
  logic [IDX_W-1:0] reg_idx;

  assign opcode       = bus.ir[15:12];
  assign is_lm        = (opcode == OP_LM);
  assign xs           = exec_decode(opcode);
  assign multi_active = (state_q == S_MULTI);

  multi_reg_seq #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .active_i    (multi_active),
    .mask_i      (bus.ir[NUM_REGS-1:0]),
    .mem_ready_i (bus.mem_ready),
    .reg_idx_o   (reg_idx),
    .bit_set_o   (bit_set),
    .last_o      (multi_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    raw     = '0;
    case (state_q)
      S_FETCH: begin
        raw.mem_rd = 1'b1;
        if (bus.mem_ready) begin
          raw.ir_wen = 1'b1;
          raw.pc_wen = 1'b1;
          raw.pc_sel = PC_INC;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_NAND, OP_ADI, OP_LHI, OP_LW, OP_SW: state_d = S_EXEC;
          OP_BEQ, OP_JAL, OP_JLR:                        state_d = S_BRANCH;
          OP_LM, OP_SM:                                  state_d = S_MULTI;
          default: begin
            raw.illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        raw.alu_a_sel   = A_REG;
        raw.alu_op      = xs.alu_op;
        raw.alu_b_sel   = xs.alu_b_sel;
        raw.rf_wadd_sel = xs.rf_wadd_sel;
        case (opcode)
          OP_ADD, OP_NAND: begin
            // A failed carry/zero condition squashes the whole instruction, flags included.
            if (cond_ok(bus.ir[1:0], bus.carry_flag, bus.zero_flag)) begin
              raw.cz_en = 1'b1;
              state_d   = S_WB;
            end else begin
              state_d   = S_FETCH;
            end
          end
          OP_ADI: begin
            raw.cz_en = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        raw.alu_op    = xs.alu_op;
        raw.alu_b_sel = xs.alu_b_sel;
        if (opcode == OP_LW) begin
          raw.mem_rd = 1'b1;
        end else begin
          raw.mem_wr = 1'b1;
        end
        if (bus.mem_ready) begin
          state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        raw.alu_op      = xs.alu_op;
        raw.alu_b_sel   = xs.alu_b_sel;
        raw.rf_wadd_sel = xs.rf_wadd_sel;
        raw.rf_din_sel  = (opcode == OP_LW) ? DIN_MEM : DIN_ALU;
        raw.rf_wen      = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        case (opcode)
          OP_BEQ: begin
            if (bus.eq) begin
              raw.pc_wen = 1'b1;
              raw.pc_sel = PC_IMM;
            end
          end
          OP_JAL, OP_JLR: begin
            // Link and jump in the same cycle: RA <= PC, PC <= target.
            raw.rf_wen      = 1'b1;
            raw.rf_wadd_sel = WA_RA;
            raw.rf_din_sel  = DIN_PC;
            raw.pc_wen      = 1'b1;
            raw.pc_sel      = (opcode == OP_JAL) ? PC_IMM : PC_REG;
          end
          default: raw.pc_wen = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      S_MULTI: begin
        if (bit_set) begin
          if (is_lm) begin
            raw.mem_rd     = 1'b1;
            raw.rf_din_sel = DIN_MEM;
            if (bus.mem_ready) begin
              raw.rf_wen      = 1'b1;
              raw.rf_wadd_sel = WA_IDX;
            end
          end else begin
            raw.mem_wr = 1'b1;
          end
        end
        if (multi_last) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset must silence a pending handshake immediately, not at the next edge.
  assign gated = rst_n ? raw : '0;

  assign bus.ir_wen      = gated.ir_wen;
  assign bus.pc_wen      = gated.pc_wen;
  assign bus.mem_rd      = gated.mem_rd;
  assign bus.mem_wr      = gated.mem_wr;
  assign bus.rf_wen      = gated.rf_wen;
  assign bus.cz_en       = gated.cz_en;
  assign bus.illegal     = gated.illegal;
  assign bus.pc_sel      = gated.pc_sel;
  assign bus.alu_a_sel   = gated.alu_a_sel;
  assign bus.alu_b_sel   = gated.alu_b_sel;
  assign bus.alu_op      = gated.alu_op;
  assign bus.rf_wadd_sel = gated.rf_wadd_sel;
  assign bus.rf_din_sel  = gated.rf_din_sel;
  assign bus.reg_idx     = rst_n ? reg_idx : '0;
  assign bus.state_id    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: steps instructions cycle by cycle and checks hand-computed strobes.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  int rf_cnt   = 0;
  int cz_cnt   = 0;
  int ill_cnt  = 0;
  int both_cnt = 0;
  int rf_base, cz_base, ill_base;

  multicycle_ctrl_if #(.IDX_W(3)) bus ();

  multicycle_ctrl #(
    .NUM_REGS (8),
    .IDX_W    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Tally strobes just before each rising edge, once inputs for the cycle are settled.
  always begin
    @(negedge clk);
    #4;
    if (bus.rf_wen === 1'b1) rf_cnt++;
    if (bus.cz_en === 1'b1) cz_cnt++;
    if (bus.illegal === 1'b1) ill_cnt++;
    if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) both_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.ir         = 16'h0000;
    bus.carry_flag = 1'b0;
    bus.zero_flag  = 1'b0;
    bus.eq         = 1'b0;
    bus.mem_ready  = 1'b0;
    #1;
    chk("rst_state",  32'(bus.state_id), 0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_ir_wen", 32'(bus.ir_wen), 0);
    chk("rst_reg_idx", 32'(bus.reg_idx), 0);

    // ADD ir=0x0000, mem_ready always 1
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    rf_base = rf_cnt; cz_base = cz_cnt;
    #1;
    chk("add_fetch_state", 32'(bus.state_id), 0);
    chk("add_fetch_mem_rd", 32'(bus.mem_rd), 1);
    chk("add_fetch_ir_wen", 32'(bus.ir_wen), 1);
    chk("add_fetch_pc_wen", 32'(bus.pc_wen), 1);
    chk("add_fetch_pc_sel", 32'(bus.pc_sel), 0);
    tick();
    chk("add_decode_state", 32'(bus.state_id), 1);
    tick();
    chk("add_exec_state", 32'(bus.state_id), 2);
    chk("add_exec_cz_en", 32'(bus.cz_en), 1);
    chk("add_exec_alu_op", 32'(bus.alu_op), 0);
    chk("add_exec_wadd", 32'(bus.rf_wadd_sel), 0);
    tick();
    chk("add_wb_state", 32'(bus.state_id), 4);
    chk("add_wb_rf_wen", 32'(bus.rf_wen), 1);
    chk("add_wb_din", 32'(bus.rf_din_sel), 0);
    tick();
    chk("add_done_state", 32'(bus.state_id), 0);
    chk("add_rf_pulses", 32'(rf_cnt - rf_base), 1);
    chk("add_cz_pulses", 32'(cz_cnt - cz_base), 1);

    // LW with mem_ready low for 3 MEM cycles
    bus.ir = 16'h4000;
    tick();
    chk("lw_decode_state", 32'(bus.state_id), 1);
    tick();
    chk("lw_exec_state", 32'(bus.state_id), 2);
    chk("lw_exec_bsel", 32'(bus.alu_b_sel), 1);
    chk("lw_exec_cz_en", 32'(bus.cz_en), 0);
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus.mem_ready = 1'b1;
      #1;
      chk("lw_mem_state", 32'(bus.state_id), 3);
      chk("lw_mem_rd", 32'(bus.mem_rd), 1);
      chk("lw_mem_wr", 32'(bus.mem_wr), 0);
    end
    tick();
    chk("lw_wb_state", 32'(bus.state_id), 4);
    chk("lw_wb_mem_rd", 32'(bus.mem_rd), 0);
    chk("lw_wb_rf_wen", 32'(bus.rf_wen), 1);
    chk("lw_wb_din", 32'(bus.rf_din_sel), 1);
    chk("lw_wb_wadd", 32'(bus.rf_wadd_sel), 2);
    tick();
    chk("lw_done_state", 32'(bus.state_id), 0);

    // ADD with carry condition false
    bus.ir = 16'h0002;
    bus.carry_flag = 1'b0;
    rf_base = rf_cnt; cz_base = cz_cnt;
    tick();
    chk("addc_decode_state", 32'(bus.state_id), 1);
    tick();
    chk("addc_exec_state", 32'(bus.state_id), 2);
    chk("addc_exec_cz_en", 32'(bus.cz_en), 0);
    tick();
    chk("addc_next_state", 32'(bus.state_id), 0);
    chk("addc_rf_pulses", 32'(rf_cnt - rf_base), 0);
    chk("addc_cz_pulses", 32'(cz_cnt - cz_base), 0);

    // JLR
    bus.ir = 16'h9000;
    tick();
    tick();
    chk("jlr_state", 32'(bus.state_id), 5);
    chk("jlr_pc_wen", 32'(bus.pc_wen), 1);
    chk("jlr_pc_sel", 32'(bus.pc_sel), 2);
    chk("jlr_rf_wen", 32'(bus.rf_wen), 1);
    chk("jlr_din", 32'(bus.rf_din_sel), 2);
    chk("jlr_wadd", 32'(bus.rf_wadd_sel), 2);
    tick();
    chk("jlr_done_state", 32'(bus.state_id), 0);

    // BEQ, eq low then raised within the BRANCH cycle
    bus.ir = 16'hC000;
    bus.eq = 1'b0;
    tick();
    tick();
    chk("beq_state", 32'(bus.state_id), 5);
    chk("beq_ne_pc_wen", 32'(bus.pc_wen), 0);
    bus.eq = 1'b1;
    #1;
    chk("beq_eq_pc_wen", 32'(bus.pc_wen), 1);
    chk("beq_eq_pc_sel", 32'(bus.pc_sel), 1);
    tick();
    chk("beq_done_state", 32'(bus.state_id), 0);

    // LM mask 0x81
    bus.ir = 16'h6081;
    rf_base = rf_cnt;
    tick();
    chk("lm_decode_state", 32'(bus.state_id), 1);
    for (int i = 0; i < 8; i++) begin
      logic exp_wen;
      tick();
      exp_wen = (i == 0 || i == 7);
      chk("lm_state", 32'(bus.state_id), 6);
      chk("lm_reg_idx", 32'(bus.reg_idx), 32'(i));
      chk("lm_rf_wen", 32'(bus.rf_wen), 32'(exp_wen));
      chk("lm_mem_rd", 32'(bus.mem_rd), 32'(exp_wen));
      if (exp_wen) chk("lm_wadd", 32'(bus.rf_wadd_sel), 3);
    end
    tick();
    chk("lm_done_state", 32'(bus.state_id), 0);
    chk("lm_done_idx", 32'(bus.reg_idx), 0);
    chk("lm_rf_pulses", 32'(rf_cnt - rf_base), 2);

    // Illegal opcode
    bus.ir = 16'hF000;
    ill_base = ill_cnt;
    tick();
    chk("ill_state", 32'(bus.state_id), 1);
    chk("ill_pulse", 32'(bus.illegal), 1);
    tick();
    chk("ill_next_state", 32'(bus.state_id), 0);
    chk("ill_after", 32'(bus.illegal), 0);
    chk("ill_pulses", 32'(ill_cnt - ill_base), 1);

    // SM mask 0x0A, reset while waiting on slot 1
    bus.ir = 16'h700A;
    tick();
    chk("sm_decode_state", 32'(bus.state_id), 1);
    bus.mem_ready = 1'b0;
    tick();
    chk("sm_slot0_state", 32'(bus.state_id), 6);
    chk("sm_slot0_mem_wr", 32'(bus.mem_wr), 0);
    tick();
    chk("sm_slot1_idx", 32'(bus.reg_idx), 1);
    chk("sm_slot1_mem_wr", 32'(bus.mem_wr), 1);
    chk("sm_slot1_mem_rd", 32'(bus.mem_rd), 0);
    tick();
    chk("sm_wait_idx", 32'(bus.reg_idx), 1);
    chk("sm_wait_mem_wr", 32'(bus.mem_wr), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("sm_rst_mem_wr", 32'(bus.mem_wr), 0);
    chk("sm_rst_mem_rd", 32'(bus.mem_rd), 0);
    chk("sm_rst_state", 32'(bus.state_id), 0);
    chk("sm_rst_idx", 32'(bus.reg_idx), 0);
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("post_rst_state", 32'(bus.state_id), 0);
    chk("post_rst_mem_rd", 32'(bus.mem_rd), 1);
    tick();
    chk("post_rst_decode", 32'(bus.state_id), 1);
    chk("rd_wr_overlap", 32'(both_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning the register-file size and the LM/SM mask width (power of two, 4..16).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_REGS), meaning the register index width.
REQ-003 SHALL have port clk, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port ir, input, 16 bits, the instruction register contents; opcode = ir[15:12].
REQ-006 SHALL have ports carry_flag and zero_flag, inputs, 1 bit each, the current ALU flags; eq, input, 1 bit, the register-compare result.
REQ-007 SHALL have port mem_ready, input, 1 bit, the memory handshake completion for the current access.
REQ-008 SHALL have outputs ir_wen, pc_wen, mem_rd, mem_wr, rf_wen, cz_en and illegal, 1 bit each, all active-high strobes.
REQ-009 SHALL have outputs pc_sel, alu_a_sel, alu_b_sel, alu_op, rf_wadd_sel and rf_din_sel, 2 bits each, the datapath mux selects.
REQ-010 SHALL have output reg_idx, IDX_W bits, the LM/SM register pointer, and output state_id, 4 bits, the current state code.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5, MULTI=6; codes 7..15 are unused and SHALL recover to FETCH.
REQ-012 SHALL in FETCH assert mem_rd and hold it until mem_ready; in the mem_ready cycle it SHALL assert ir_wen and pc_wen with pc_sel=00 (PC+1), then go to DECODE.
REQ-013 SHALL in DECODE select by opcode: 0000 ADD, 0010 NAND, 0001 ADI, 0011 LHI, 0100 LW and 0101 SW go to EXEC; 1100 BEQ, 1000 JAL and 1001 JLR go to BRANCH; 0110 LM and 0111 SM go to MULTI.
REQ-014 SHALL treat any other opcode in DECODE as illegal: pulse illegal for one cycle and return to FETCH.
REQ-015 SHALL in EXEC drive alu_op=00 for add and 01 for NAND; ADD and NAND use alu_b_sel=00 (register); ADI, LW and SW use alu_b_sel=01 (imm6 sign-extended); LHI uses alu_b_sel=10 (imm9<<7) with alu_op=10 (pass B).
REQ-016 SHALL assert cz_en in EXEC for ADD, ADI and NAND only.
REQ-017 SHALL gate ADD/NAND on ir[1:0]: 10 requires carry_flag=1 and 01 requires zero_flag=1; if the condition fails, cz_en and the WB write are suppressed and the state goes to FETCH.
REQ-018 SHALL route EXEC to MEM for LW/SW and to WB for the others; rf_wadd_sel is 00 (RC) for ADD/NAND, 01 (RB) for ADI, and 10 (RA) for LHI/LW.
REQ-019 SHALL in MEM assert mem_rd for LW or mem_wr for SW until mem_ready; then LW goes to WB with rf_din_sel=01 (mem) and SW goes to FETCH.
REQ-020 SHALL in WB pulse rf_wen for exactly one cycle, with rf_din_sel=00 (ALU) unless set by REQ-019, then go to FETCH.
REQ-021 SHALL in BRANCH for BEQ pulse pc_wen with pc_sel=01 (PC+imm6) only if eq=1.
REQ-022 SHALL in BRANCH for JAL pulse rf_wen (RA, rf_din_sel=10, PC) and pc_wen with pc_sel=01 (imm9); JLR SHALL use pc_sel=10 (RB). BRANCH takes 1 cycle, then FETCH.
REQ-023 SHALL in MULTI scan reg_idx from 0 to NUM_REGS-1 against mask ir[NUM_REGS-1:0]; a clear bit costs 1 cycle with no strobes.
REQ-024 SHALL for each set mask bit in MULTI assert mem_rd (LM) or mem_wr (SM) until mem_ready; LM SHALL pulse rf_wen in the ready cycle with rf_wadd_sel=11 (reg_idx).
REQ-025 SHALL advance reg_idx only after a completed or skipped slot; after slot NUM_REGS-1 it SHALL return to FETCH with reg_idx=0, and a zero mask SHALL take exactly NUM_REGS cycles.
REQ-026 SHALL never assert mem_rd and mem_wr together, and SHALL never assert rf_wen and cz_en for the same instruction except ADD/ADI/NAND.

Reset
REQ-027 SHALL on rst_n low, immediately and at any state (including a pending handshake), force state FETCH, reg_idx 0, and all strobes and selects 0.
REQ-028 SHALL start the first fetch in the first rising clk edge after rst_n deasserts.

Structure
REQ-029 SHALL take state codes, opcode constants and select encodings from shared package riscmc_pkg.
REQ-030 SHALL place the LM/SM mask scanner (reg_idx counter plus bit-test) in sub-module multi_reg_seq.

Verification
REQ-031 SHALL test ADD with ir=0x0000 and mem_ready=1 in every cycle: states FETCH,DECODE,EXEC,WB, one rf_wen pulse, cz_en=1 in EXEC, cycles 4.
REQ-032 SHALL test ADD with ir[1:0]=10 and carry_flag=0: no rf_wen, no cz_en, return to FETCH after EXEC.
REQ-033 SHALL test LW with mem_ready delayed 3 cycles in MEM: mem_rd held 4 cycles, then WB with rf_din_sel=01.
REQ-034 SHALL test LM with mask 0x81 and NUM_REGS=8: rf_wen at reg_idx 0 and 7 only, 8 slots, then FETCH.
REQ-035 SHALL test opcode 1111: illegal pulses once and the next state is FETCH.
REQ-036 SHALL test rst_n low mid-SM during wait: outputs drop to 0 asynchronously and state_id=0.
